// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Handshake/operand bundle for the digit-serial adder.
//   master : requester side  (drives start/sub/a/b/c_in, observes results)
//   slave  : adder side      (observes request, drives busy/done/sum/c_out/overflow)
//   start    request pulse, accepted only while the adder is idle or done
//   sub      0 = add, 1 = subtract (sampled with start)
//   a, b     operands (sampled with start)
//   c_in     carry-in / borrow-in (sampled with start)
//   busy     high while digits are being processed
//   done     one-cycle pulse when the result becomes valid
//   sum      result, held until the next accepted start completes
//   c_out    carry out of the MSB (subtract: 1 = no borrow)
//   overflow two's-complement signed overflow
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
//   Digit-serial add/subtract engine. One DIGIT-bit full-adder slice with a
//   registered carry walks the operands LSB first, one digit per clock.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  serial_adder_if.slave (start/sub/a/b/c_in in; busy/done/sum/c_out/overflow out)
//   Timing: start accepted in cycle T -> busy T+1..T+N -> done pulse at T+N+1,
//   N = WIDTH/DIGIT. A start in the done cycle begins the next operation.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_sh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, c_out_q, ovf_q;
    logic [WIDTH-1:0] sum_q;

    // Slice outputs for the current digit
    logic [DIGIT-1:0] dsum;
    logic             carry_d;     // carry out of the slice
    logic             cmsb;        // carry into the slice's top bit
    logic [WIDTH-1:0] a_d, b_d, sum_sh_d;
    logic             accept;
    logic             last;

    // Ripple through the DIGIT bits of the slice. The carry into the top bit
    // is kept separately: on the final digit it is the carry into the MSB,
    // which together with the carry out gives signed overflow.
    always_comb begin
        logic c;
        c    = carry_q;
        cmsb = 1'b0;
        dsum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) cmsb = c;
            dsum[i] = a_q[i] ^ b_q[i] ^ c;
            c       = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        carry_d = c;
    end

    // Operands shift right by a digit; the new digit enters the sum
    // register from the MSB side so it ends up LSB-aligned after N steps.
    always_comb begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        sum_sh_d = sum_sh_q >> DIGIT;
        sum_sh_d[WIDTH-1 -: DIGIT] = dsum;
    end

    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    assign last   = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (state_q == DONE) done_q <= 1'b0;

            if (accept) begin
                // Subtract is a + ~b + ~borrow_in.
                a_q      <= bus.a;
                b_q      <= bus.sub ? ~bus.b : bus.b;
                carry_q  <= bus.sub ^ bus.c_in;
                sum_sh_q <= '0;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        a_q      <= a_d;
                        b_q      <= b_d;
                        sum_sh_q <= sum_sh_d;
                        carry_q  <= carry_d;
                        cnt_q    <= cnt_q + CW'(1);
                        if (last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sum_q   <= sum_sh_d;
                            c_out_q <= carry_d;
                            ovf_q   <= cmsb ^ carry_d;
                            state_q <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(8))  b8 ();
    serial_adder_if #(.WIDTH(16)) b16 ();

    serial_adder #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        ov;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expectation per DUT.
    always @(negedge clk) begin
        if (!rst && b8.done === 1'b1) begin
            if (q8.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done8 actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e8 = q8.pop_front();
                chk({e8.name, "_sum"},   {24'h0, b8.sum},      {16'h0, e8.sum});
                chk({e8.name, "_cout"},  {31'h0, b8.c_out},    {31'h0, e8.c});
                chk({e8.name, "_ovf"},   {31'h0, b8.overflow}, {31'h0, e8.ov});
                chk({e8.name, "_cycle"}, cyc,                  e8.cyc);
            end
        end
        if (!rst && b16.done === 1'b1) begin
            if (q16.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done16 actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e16 = q16.pop_front();
                chk({e16.name, "_sum"},   {16'h0, b16.sum},      {16'h0, e16.sum});
                chk({e16.name, "_cout"},  {31'h0, b16.c_out},    {31'h0, e16.c});
                chk({e16.name, "_ovf"},   {31'h0, b16.overflow}, {31'h0, e16.ov});
                chk({e16.name, "_cycle"}, cyc,                   e16.cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge (cycle T); start is sampled at the next edge.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ci,
                       input logic [7:0] es, input logic ec, input logic eo,
                       input string nm, input bit push);
        b8.a = a; b8.b = b; b8.sub = s; b8.c_in = ci; b8.start = 1'b1;
        if (push) q8.push_back('{sum: {8'h0, es}, c: ec, ov: eo, cyc: cyc + 9, name: nm});
        step(1);
        b8.start = 1'b0;
    endtask

    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci,
                        input logic [15:0] es, input logic ec, input logic eo, input string nm);
        b16.a = a; b16.b = b; b16.sub = s; b16.c_in = ci; b16.start = 1'b1;
        q16.push_back('{sum: es, c: ec, ov: eo, cyc: cyc + 5, name: nm});
        step(1);
        b16.start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        b8.start = 0;  b8.sub = 0;  b8.a = '0;  b8.b = '0;  b8.c_in = 0;
        b16.start = 0; b16.sub = 0; b16.a = '0; b16.b = '0; b16.c_in = 0;
        #12;
        chk("rst_busy",  {31'h0, b8.busy},     32'h0);
        chk("rst_done",  {31'h0, b8.done},     32'h0);
        chk("rst_sum",   {24'h0, b8.sum},      32'h0);
        chk("rst_cout",  {31'h0, b8.c_out},    32'h0);
        chk("rst_ovf",   {31'h0, b8.overflow}, 32'h0);
        chk("rst_sum16", {16'h0, b16.sum},     32'h0);
        @(negedge clk) rst = 1'b0;
        step(1);

        // 0x3C + 0x5A: busy exactly 8 cycles, done at T+9, result held.
        go8(8'h3C, 8'h5A, 0, 0, 8'h96, 0, 1, "add_3c_5a", 1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("busy_v1_k%0d", k), {31'h0, b8.busy}, (k <= 8) ? 32'h1 : 32'h0);
        end
        step(3);
        chk("hold_sum",  {24'h0, b8.sum},      32'h96);
        chk("hold_cout", {31'h0, b8.c_out},    32'h0);
        chk("hold_ovf",  {31'h0, b8.overflow}, 32'h1);
        chk("hold_done", {31'h0, b8.done},     32'h0);

        go8(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, "add_ff_01",    1); step(9);
        go8(8'hFF, 8'h00, 0, 1, 8'h00, 1, 0, "add_ff_00_ci", 1); step(9);
        go8(8'h10, 8'h20, 1, 0, 8'hF0, 0, 0, "sub_10_20",    1); step(9);
        go8(8'h80, 8'h01, 1, 0, 8'h7F, 1, 1, "sub_80_01",    1); step(9);

        // Start while busy is ignored; start in the done cycle is accepted.
        go8(8'h12, 8'h34, 0, 0, 8'h46, 0, 0, "add_12_34", 1);   // now T+1
        step(3);                                                // T+4
        b8.a = 8'hFF; b8.b = 8'hFF; b8.sub = 1; b8.c_in = 1; b8.start = 1'b1;
        step(1);                                                // T+5
        b8.start = 1'b0;
        step(4);                                                // T+9 (done cycle)
        go8(8'h01, 8'h02, 0, 0, 8'h03, 0, 0, "b2b_01_02", 1);
        chk("b2b_busy",     {31'h0, b8.busy}, 32'h1);
        chk("b2b_held_sum", {24'h0, b8.sum},  32'h46);
        step(9);

        // Reset mid-run discards the operation; no done follows.
        go8(8'h0F, 8'h0F, 0, 0, 8'h00, 0, 0, "discarded", 0);   // T+1
        step(4);                                                // T+5
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'h0, b8.busy},     32'h0);
        chk("midrst_done", {31'h0, b8.done},     32'h0);
        chk("midrst_sum",  {24'h0, b8.sum},      32'h0);
        chk("midrst_cout", {31'h0, b8.c_out},    32'h0);
        chk("midrst_ovf",  {31'h0, b8.overflow}, 32'h0);
        @(negedge clk) rst = 1'b0;
        step(12);
        go8(8'h55, 8'h22, 0, 0, 8'h77, 0, 0, "post_rst_55_22", 1);
        step(9);

        // WIDTH=16, DIGIT=4
        go16(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, "w16_add_7fff_1");
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("busy16_k%0d", k), {31'h0, b16.busy}, (k <= 4) ? 32'h1 : 32'h0);
        end
        step(1);
        go16(16'h0000, 16'h0001, 1, 0, 16'hFFFF, 0, 0, "w16_sub_0_1");    step(5);
        go16(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, "w16_sub_8000_1"); step(5);

        for (int i = 0; i < 20 && (q8.size() != 0 || q16.size() != 0); i++) step(1);
        chk("q8_drained",  q8.size(),  32'h0);
        chk("q16_drained", q16.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, digit-serial add/subtract unit built around a DIGIT-bit full-adder slice with a registered carry.
- Processes one DIGIT-bit digit per clock, LSB first, under a start/busy/done handshake.
- Adds subtract mode, signed overflow detection and held results.
- Serves as the area-lean arithmetic engine for datapath practicals where operand width exceeds what a single-cycle ripple adder should span.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- c_in  input  1  carry-in (add) or borrow-in (subtract); sampled with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- c_out  output  1  raw carry out of the MSB; in subtract mode, 1 = no borrow.
- overflow  output  1  signed overflow (two's complement) of the operation.

Behaviour:
- N = WIDTH/DIGIT.
- FSM states:
  - IDLE: waits for start.
  - RUN: N cycles, one digit per cycle.
  - DONE: exactly one cycle; done=1. Returns to IDLE, or to RUN if start is accepted in that cycle.
- Accept, in cycle T with start=1 in IDLE or DONE:
  - Latch a; latch b (b is bitwise inverted when sub=1).
  - Carry register = sub ? ~c_in : c_in.
  - Digit counter = 0.
- Cycles T+1..T+N: busy=1.
  - Each cycle adds the low DIGIT bits of the A/B shift registers plus the carry register.
  - The digit result is shifted into the sum shift register from the MSB side; the carry register is updated; the counter increments.
- Cycle T+N+1:
  - busy=0, done=1.
  - sum, c_out and overflow are updated and stable from this cycle on.
- Latency: start to done = N+1 cycles.
- Back-to-back: a start accepted in DONE gives the next done at T+N+1 relative to that start.
- start while busy=1 is ignored; operands and mode are not re-sampled.
- Output registers are written only at the end of RUN. They hold their values through IDLE and through the next RUN.
- Arithmetic: sum = (a + B' + cin') mod 2^WIDTH, where B' = sub ? ~b : b and cin' is the initial carry.
  - c_out = bit WIDTH of that sum.
  - overflow = carry into the MSB XOR c_out. With DIGIT>1 this uses the internal carry of the last digit slice.
- sub and c_in changes outside the accept cycle have no effect.
- Reset (any state, including mid-RUN):
  - FSM returns to IDLE.
  - busy=0, done=0, sum=0, c_out=0, overflow=0; internal shift registers, carry and counter cleared.
  - The in-flight operation is discarded; no done pulse follows.
- The first start after reset deasserts is handled normally.

Test Plan:
- WIDTH=8, DIGIT=1; start in cycle T with a=0x3C, b=0x5A, sub=0, c_in=0 -> busy high T+1..T+8; done=1 only at T+9; sum=0x96, c_out=0, overflow=1; values held afterwards.
- a=0xFF, b=0x01, sub=0, c_in=0 -> sum=0x00, c_out=1, overflow=0. Repeat with c_in=1, b=0x00 -> sum=0x00, c_out=1, overflow=0.
- sub=1, c_in=0, a=0x10, b=0x20 -> sum=0xF0, c_out=0 (borrow), overflow=0. Then a=0x80, b=0x01 -> sum=0x7F, c_out=1, overflow=1.
- Pulse start again at T+4 with different operands -> ignored; first result unchanged at T+9. Then start asserted in the done cycle with a=0x01, b=0x02 -> busy next cycle; done 9 cycles later; sum=0x03.
- Assert rst at T+5 mid-RUN -> all outputs 0 immediately (async); no done pulse; a new start after release completes correctly.
- WIDTH=16, DIGIT=4; a=0x7FFF, b=0x0001, sub=0, c_in=0 -> busy 4 cycles; done at T+5; sum=0x8000, c_out=0, overflow=1.
